// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave front end.
// States, command encodings and frame lengths.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int RX_BITS = 10;
  localparam int TX_BITS = 8;

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// Serial pins plus the RAM-facing word/byte handshake of the SPI slave.
interface spi_slave_bus_if #(parameter int DATA_W = 8);

  logic              MOSI;
  logic              SS_n;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  MOSI, SS_n, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output MOSI, SS_n, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave_if_tx_serializer.sv
// Loads the RAM read byte and shifts it out MSB first; done marks the cycle bit 0 is on MISO.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  logic [DATA_W-1:0] shreg;

  // MISO falls back to 0 on any cycle that is not an active shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      miso  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      shreg <= data;
      miso  <= 1'b0;
      done  <= 1'b0;
    end else if (shift) begin
      miso  <= shreg[DATA_W-1];
      shreg <= {shreg[DATA_W-2:0], 1'b0};
      done  <= last;
    end else begin
      miso  <= 1'b0;
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: 10-bit MOSI frames to the RAM, RAM read byte back on MISO.
// Define SPI_FRAME_ERR_EN to add the frame_err abort strobe.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CMD_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_bus_if.slave  bus
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic            frame_err
`endif
);

  localparam logic [3:0] RX_LAST = 4'(RX_BITS - 1);
  localparam logic [3:0] TX_LAST = 4'(TX_BITS - 1);

  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [DATA_W+CMD_W-2:0] rx_shift;
  logic rx_done, tx_loaded, rd_addr_seen;
  logic shift_in, frame_done, load, shift_out, ser_done, rd_clear, incomplete;

  // Frame type comes from the first bit; SS_n high anywhere but IDLE aborts.
  always_comb begin
    state_nxt  = state;
    shift_in   = 1'b0;
    frame_done = 1'b0;
    load       = 1'b0;
    shift_out  = 1'b0;
    rd_clear   = 1'b0;
    incomplete = 1'b0;
    case (state)
      IDLE:     if (!bus.SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        shift_in   = 1'b1;
        incomplete = 1'b1;
        if (!bus.MOSI)         state_nxt = WRITE;
        else if (rd_addr_seen) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      WRITE, READ_ADD: begin
        if (!rx_done) begin
          shift_in   = 1'b1;
          incomplete = 1'b1;
          frame_done = (cnt == RX_LAST);
        end
      end
      READ_DATA: begin
        if (!rx_done) begin
          shift_in   = 1'b1;
          incomplete = 1'b1;
          frame_done = (cnt == RX_LAST);
        end else if (!tx_loaded) begin
          load = bus.tx_valid;
        end else if (!ser_done) begin
          shift_out  = 1'b1;
          incomplete = 1'b1;
        end else begin
          rd_clear  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
    if (state != IDLE && bus.SS_n) begin
      state_nxt  = IDLE;
      shift_in   = 1'b0;
      frame_done = 1'b0;
      load       = 1'b0;
      shift_out  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rx_shift     <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      rx_done      <= 1'b0;
      tx_loaded    <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.rx_valid <= frame_done;
      if (state_nxt == IDLE) begin
        cnt       <= 4'd0;
        rx_done   <= 1'b0;
        tx_loaded <= 1'b0;
      end else if (shift_in) begin
        rx_shift <= {rx_shift[DATA_W+CMD_W-3:0], bus.MOSI};
        cnt      <= sat_inc(cnt, RX_LAST);
        if (frame_done) begin
          rx_done     <= 1'b1;
          bus.rx_data <= {rx_shift, bus.MOSI};
        end
      end else if (load) begin
        tx_loaded <= 1'b1;
        cnt       <= 4'd0;
      end else if (shift_out) begin
        cnt <= sat_inc(cnt, TX_LAST);
      end
      if (frame_done && state == READ_ADD) rd_addr_seen <= 1'b1;
      else if (rd_clear)                   rd_addr_seen <= 1'b0;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= (state != IDLE) && bus.SS_n && incomplete;
  end
`endif

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_out),
    .last  (cnt == TX_LAST),
    .data  (bus.tx_data),
    .miso  (bus.MISO),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write/read frames, abort, back-to-back, reset mid-serialise.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int n_asserts = 0;
  int n_fail = 0;
  int pulses;
  logic [9:0] last_rx;
  logic miso_any;
  logic [7:0] exp_byte;

  spi_slave_bus_if #(.DATA_W(8)) bus ();

`ifdef SPI_FRAME_ERR_EN
  logic frame_err;
`endif

  spi_slave_if #(.DATA_W(8), .CMD_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic cycle(input logic ss, input logic mosi);
    bus.SS_n = ss;
    bus.MOSI = mosi;
    @(negedge clk);
  endtask

  task automatic track();
    if (bus.rx_valid === 1'b1) begin
      pulses++;
      last_rx = bus.rx_data;
    end
    if (bus.MISO !== 1'b0) miso_any = 1'b1;
  endtask

  task automatic send_bits(input logic [9:0] bits, input int n);
    cycle(1'b0, 1'b0);
    track();
    for (int i = 9; i > 9 - n; i--) begin
      cycle(1'b0, bits[i]);
      track();
    end
  endtask

  task automatic end_frame();
    cycle(1'b1, 1'b0);
    track();
  endtask

  initial begin
    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    exp_byte = 8'hA5;
    repeat (2) @(negedge clk);
    check("rst_miso", bus.MISO, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_state", dut.state, IDLE);
    check("rst_rd_seen", dut.rd_addr_seen, 0);
    rst = 1'b0;
    cycle(1'b1, 1'b0);

    $display("[TB] write address");
    pulses = 0; miso_any = 1'b0;
    send_bits(10'h005, 10);
    check("wa_rx_valid", bus.rx_valid, 1);
    check("wa_rx_data", bus.rx_data, 10'h005);
    end_frame();
    check("wa_pulses", pulses, 1);
    check("wa_miso", miso_any, 0);
    check("wa_state", dut.state, IDLE);
`ifdef SPI_FRAME_ERR_EN
    check("wa_frame_err", frame_err, 0);
`endif

    $display("[TB] write data with stray tx_valid");
    pulses = 0; miso_any = 1'b0;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h3C;
    send_bits(10'h1AA, 10);
    check("wd_rx_data", bus.rx_data, 10'h1AA);
    end_frame();
    bus.tx_valid = 1'b0;
    check("wd_pulses", pulses, 1);
    check("wd_miso", miso_any, 0);
    check("wd_rd_seen", dut.rd_addr_seen, 0);

    $display("[TB] read address");
    pulses = 0;
    send_bits(10'h205, 10);
    check("ra_rx_data", bus.rx_data, 10'h205);
    end_frame();
    check("ra_pulses", pulses, 1);
    check("ra_rd_seen", dut.rd_addr_seen, 1);

    $display("[TB] read data");
    pulses = 0;
    send_bits(10'h300, 10);
    check("rd_rx_valid", bus.rx_valid, 1);
    check("rd_rx_data", bus.rx_data, 10'h300);
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    cycle(1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    track();
    check("rd_load_miso", bus.MISO, 0);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b0);
      track();
      check($sformatf("rd_miso_bit%0d", i), bus.MISO, exp_byte[i]);
    end
    cycle(1'b0, 1'b0);
    check("rd_miso_after", bus.MISO, 0);
    check("rd_state", dut.state, IDLE);
    check("rd_rd_seen", dut.rd_addr_seen, 0);
    check("rd_pulses", pulses, 1);
    cycle(1'b1, 1'b0);

    $display("[TB] abort after 6 bits");
    pulses = 0;
    send_bits(10'b01_1010_0000, 6);
    end_frame();
    check("ab_pulses", pulses, 0);
    check("ab_state", dut.state, IDLE);
    check("ab_rx_data", bus.rx_data, 10'h300);
    check("ab_cnt", dut.cnt, 0);
`ifdef SPI_FRAME_ERR_EN
    check("ab_frame_err_hi", frame_err, 1);
    cycle(1'b1, 1'b0);
    check("ab_frame_err_lo", frame_err, 0);
`else
    cycle(1'b1, 1'b0);
`endif

    $display("[TB] back-to-back frames");
    pulses = 0;
    send_bits(10'h0FF, 10);
    check("bb_first", bus.rx_data, 10'h0FF);
    end_frame();
    send_bits(10'h17E, 10);
    check("bb_second", bus.rx_data, 10'h17E);
    end_frame();
    check("bb_pulses", pulses, 2);
    check("bb_last_rx", last_rx, 10'h17E);

    $display("[TB] reset during serialise");
    send_bits(10'h205, 10);
    end_frame();
    send_bits(10'h300, 10);
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    cycle(1'b0, 1'b0);
    bus.tx_valid = 1'b0;
    repeat (5) cycle(1'b0, 1'b0);
    check("rs_bit3", bus.MISO, exp_byte[3]);
    check("rs_rd_seen_pre", dut.rd_addr_seen, 1);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    check("rs_miso", bus.MISO, 0);
    check("rs_rx_valid", bus.rx_valid, 0);
    check("rs_state", dut.state, IDLE);
    check("rs_rd_seen", dut.rd_addr_seen, 0);
    check("rs_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    cycle(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
